// File: rtl/trace_pkg.sv
// Shared types for the commit trace checker: record layout, kind and error
// encodings, checker state, and the single-record match rule.
package trace_pkg;
  localparam int DATA_W = 16;
  localparam int MAX_EV = 4;

  localparam logic [1:0] KIND_REG   = 2'd0;
  localparam logic [1:0] KIND_LOAD  = 2'd1;
  localparam logic [1:0] KIND_STORE = 2'd2;
  localparam logic [1:0] KIND_HALT  = 2'd3;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISMATCH = 2'd1;
  localparam logic [1:0] ERR_STARVED  = 2'd2;
  localparam logic [1:0] ERR_EXTRA    = 2'd3;

  typedef struct packed {
    logic [1:0]        kind;
    logic [DATA_W-1:0] tag;
    logic [DATA_W-1:0] value;
  } rec_t;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PASS, ST_FAIL} state_e;

  // HALT carries no payload, so only its kind takes part in the compare.
  function automatic logic rec_match(rec_t exp, rec_t got);
    if (exp.kind != got.kind) return 1'b0;
    if (exp.kind == KIND_HALT) return 1'b1;
    return (exp.tag == got.tag) && (exp.value == got.value);
  endfunction
endpackage

// File: rtl/commit_trace_checker_if.sv
// Golden-record push port plus the live commit signals observed by the checker.
interface commit_trace_checker_if;
  logic        exp_valid;
  logic [1:0]  exp_kind;
  logic [15:0] exp_tag;
  logic [15:0] exp_value;
  logic        exp_ready;

  logic        c_regwrite;
  logic        c_memread;
  logic        c_memwrite;
  logic        c_halt;
  logic [2:0]  c_wreg;
  logic [15:0] c_wdata;
  logic [15:0] c_maddr;
  logic [15:0] c_mdin;
  logic [15:0] c_mdout;

  modport master (
    output exp_valid, exp_kind, exp_tag, exp_value,
    output c_regwrite, c_memread, c_memwrite, c_halt,
    output c_wreg, c_wdata, c_maddr, c_mdin, c_mdout,
    input  exp_ready
  );

  modport slave (
    input  exp_valid, exp_kind, exp_tag, exp_value,
    input  c_regwrite, c_memread, c_memwrite, c_halt,
    input  c_wreg, c_wdata, c_maddr, c_mdin, c_mdout,
    output exp_ready
  );
endinterface

// File: rtl/trace_fifo.sv
// Register FIFO of golden records: one push per cycle, pop of 0..MAX_EV entries,
// with the first MAX_EV entries exposed combinationally for comparison.
module trace_fifo
  import trace_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  rec_t                 push_rec,
  input  logic [2:0]           pop_n,
  output rec_t [MAX_EV-1:0]    head,
  output logic [CW-1:0]        count
);
  rec_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Caller guarantees no push when full and pop_n <= count.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    if (push) begin
      mem_d[wptr_q] = push_rec;
      wptr_d        = wptr_q + PW'(1);
    end
    rptr_d = rptr_q + PW'(pop_n);
    cnt_d  = cnt_q + CW'(push) - CW'(pop_n);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read below the count.
  always_ff @(posedge clk) mem_q <= mem_d;

  for (genvar k = 0; k < MAX_EV; k++) begin : g_head
    logic [PW-1:0] idx;
    assign idx     = rptr_q + PW'(k);
    assign head[k] = mem_q[idx];
  end

  assign count = cnt_q;
endmodule

// File: rtl/commit_trace_checker.sv
// Compares each cycle's architectural commit events against a streamed golden
// trace and reports pass, first error kind and the cycle it happened on.
module commit_trace_checker
  import trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CYC_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  commit_trace_checker_if.slave tif,
  output logic                  busy,
  output logic                  pass,
  output logic                  fail,
  output logic [1:0]            err_code,
  output logic [CYC_W-1:0]      err_cycle,
  output logic [CYC_W-1:0]      check_count
);
  localparam int CW = $clog2(DEPTH) + 1;

  state_e             state_q, state_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [1:0]         err_code_q, err_code_d;
  logic [CYC_W-1:0]   err_cycle_q, err_cycle_d;
  logic [CYC_W-1:0]   chk_q, chk_d;

  rec_t [MAX_EV-1:0]  head;
  logic [CW-1:0]      cnt;
  logic [2:0]         pop_n;
  logic               push;
  rec_t               push_rec;

  rec_t [MAX_EV-1:0]  ev;
  logic [2:0]         n_ev;
  logic [MAX_EV-1:0]  slot_bad;
  logic               starved;
  logic [CW-1:0]      remain;

  assign tif.exp_ready = (cnt < CW'(DEPTH)) && (state_q == ST_IDLE || state_q == ST_RUN);
  assign push          = tif.exp_valid && tif.exp_ready;
  assign push_rec      = '{kind: tif.exp_kind, tag: tif.exp_tag, value: tif.exp_value};

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_rec (push_rec),
    .pop_n    (pop_n),
    .head     (head),
    .count    (cnt)
  );

  // Pack this cycle's events in fixed REG, LOAD, STORE, HALT order so that
  // event k lines up with FIFO entry head+k.
  always_comb begin
    ev   = '0;
    n_ev = '0;
    if (tif.c_regwrite) begin
      ev[n_ev[1:0]] = '{kind: KIND_REG, tag: {{(DATA_W-3){1'b0}}, tif.c_wreg}, value: tif.c_wdata};
      n_ev          = n_ev + 3'd1;
    end
    if (tif.c_memread) begin
      ev[n_ev[1:0]] = '{kind: KIND_LOAD, tag: tif.c_maddr, value: tif.c_mdout};
      n_ev          = n_ev + 3'd1;
    end
    if (tif.c_memwrite) begin
      ev[n_ev[1:0]] = '{kind: KIND_STORE, tag: tif.c_maddr, value: tif.c_mdin};
      n_ev          = n_ev + 3'd1;
    end
    if (tif.c_halt) begin
      ev[n_ev[1:0]] = '{kind: KIND_HALT, tag: '0, value: '0};
      n_ev          = n_ev + 3'd1;
    end
  end

  for (genvar k = 0; k < MAX_EV; k++) begin : g_cmp
    assign slot_bad[k] = (3'(k) < n_ev) && !rec_match(head[k], ev[k]);
  end

  assign starved = cnt < CW'(n_ev);
  assign remain  = cnt - CW'(n_ev);

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    err_code_d  = err_code_q;
    err_cycle_d = err_cycle_q;
    chk_d       = chk_q;
    pop_n       = '0;
    case (state_q)
      ST_IDLE: if (enable) state_d = ST_RUN;
      ST_RUN: begin
        if (~&cyc_q) cyc_d = cyc_q + CYC_W'(1);
        if (starved) begin
          state_d     = ST_FAIL;
          err_code_d  = ERR_STARVED;
          err_cycle_d = cyc_q;
        end else if (|slot_bad) begin
          state_d     = ST_FAIL;
          err_code_d  = ERR_MISMATCH;
          err_cycle_d = cyc_q;
        end else begin
          pop_n = n_ev;
          chk_d = chk_q + CYC_W'(n_ev);
          // HALT is always last in the event list, so it matched here.
          if (tif.c_halt) begin
            if (remain != '0) begin
              state_d     = ST_FAIL;
              err_code_d  = ERR_EXTRA;
              err_cycle_d = cyc_q;
            end else begin
              state_d = ST_PASS;
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cyc_q       <= '0;
      err_code_q  <= ERR_NONE;
      err_cycle_q <= '0;
      chk_q       <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      err_code_q  <= err_code_d;
      err_cycle_q <= err_cycle_d;
      chk_q       <= chk_d;
    end
  end

  assign busy        = (state_q == ST_RUN);
  assign pass        = (state_q == ST_PASS);
  assign fail        = (state_q == ST_FAIL);
  assign err_code    = err_code_q;
  assign err_cycle   = err_cycle_q;
  assign check_count = chk_q;
endmodule

// File: tb/tb_commit_trace_checker.sv
// Directed bench for commit_trace_checker: one task per scenario, inline checks.
module tb_commit_trace_checker;
  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        busy, pass, fail;
  logic [1:0]  err_code;
  logic [15:0] err_cycle, check_count;
  int          total = 0;
  int          bad   = 0;

  commit_trace_checker_if tif();

  commit_trace_checker #(.DEPTH(8), .CYC_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .tif         (tif.slave),
    .busy        (busy),
    .pass        (pass),
    .fail        (fail),
    .err_code    (err_code),
    .err_cycle   (err_cycle),
    .check_count (check_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_commit();
    tif.c_regwrite = 1'b0; tif.c_memread = 1'b0; tif.c_memwrite = 1'b0; tif.c_halt = 1'b0;
    tif.c_wreg = '0; tif.c_wdata = '0; tif.c_maddr = '0; tif.c_mdin = '0; tif.c_mdout = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; tif.exp_valid = 1'b0;
    clear_commit();
    tick();
    rst = 1'b0;
  endtask

  task automatic push_rec(input logic [1:0] kind, input logic [15:0] tag, input logic [15:0] val);
    tif.exp_valid = 1'b1; tif.exp_kind = kind; tif.exp_tag = tag; tif.exp_value = val;
    tick();
    tif.exp_valid = 1'b0;
  endtask

  task automatic start_run();
    enable = 1'b1;
    tick();
    enable = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (busy !== 1'b0)        begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
    total++; if (pass !== 1'b0)        begin bad++; $display("FAIL reset_pass got=%0b want=0", pass); end
    total++; if (fail !== 1'b0)        begin bad++; $display("FAIL reset_fail got=%0b want=0", fail); end
    total++; if (err_code !== 2'd0)    begin bad++; $display("FAIL reset_err_code got=%0d want=0", err_code); end
    total++; if (err_cycle !== 16'd0)  begin bad++; $display("FAIL reset_err_cycle got=%0d want=0", err_cycle); end
    total++; if (check_count !== 16'd0) begin bad++; $display("FAIL reset_check_count got=%0d want=0", check_count); end
    total++; if (tif.exp_ready !== 1'b1) begin bad++; $display("FAIL reset_exp_ready got=%0b want=1", tif.exp_ready); end
  endtask

  task automatic test_basic();
    do_reset();
    push_rec(2'd0, 16'd3, 16'h1234);
    push_rec(2'd2, 16'h0040, 16'h00AA);
    push_rec(2'd3, 16'h0000, 16'h0000);
    // A bogus commit alongside enable must not be checked.
    tif.c_regwrite = 1'b1; tif.c_wreg = 3'd7; tif.c_wdata = 16'hDEAD;
    start_run();
    clear_commit();
    total++; if (busy !== 1'b1 || fail !== 1'b0) begin bad++; $display("FAIL basic_enable_cycle got busy=%0b fail=%0b want busy=1 fail=0", busy, fail); end
    tif.c_regwrite = 1'b1; tif.c_wreg = 3'd3; tif.c_wdata = 16'h1234;
    tick(); clear_commit();
    total++; if (check_count !== 16'd1) begin bad++; $display("FAIL basic_reg_count got=%0d want=1", check_count); end
    tif.c_memwrite = 1'b1; tif.c_maddr = 16'h0040; tif.c_mdin = 16'h00AA;
    tick(); clear_commit();
    total++; if (check_count !== 16'd2) begin bad++; $display("FAIL basic_store_count got=%0d want=2", check_count); end
    tif.c_halt = 1'b1;
    tick(); clear_commit();
    total++; if (pass !== 1'b1 || fail !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL basic_pass got pass=%0b fail=%0b busy=%0b want 1/0/0", pass, fail, busy); end
    total++; if (check_count !== 16'd3) begin bad++; $display("FAIL basic_halt_count got=%0d want=3", check_count); end
    total++; if (tif.exp_ready !== 1'b0) begin bad++; $display("FAIL basic_ready_in_pass got=%0b want=0", tif.exp_ready); end
  endtask

  task automatic test_multi();
    do_reset();
    push_rec(2'd0, 16'd1, 16'h0005);
    push_rec(2'd1, 16'h0010, 16'h0005);
    start_run();
    tif.c_regwrite = 1'b1; tif.c_wreg = 3'd1; tif.c_wdata = 16'h0005;
    tif.c_memread = 1'b1; tif.c_maddr = 16'h0010; tif.c_mdout = 16'h0005;
    tick(); clear_commit();
    total++; if (check_count !== 16'd2) begin bad++; $display("FAIL multi_count got=%0d want=2", check_count); end
    total++; if (fail !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL multi_state got fail=%0b busy=%0b want 0/1", fail, busy); end
  endtask

  task automatic test_mismatch();
    do_reset();
    push_rec(2'd0, 16'd2, 16'h0001);
    start_run();
    // Cycle counter reads 0 in the first RUN cycle; error lands with it at 4.
    for (int i = 0; i < 4; i++) tick();
    tif.c_regwrite = 1'b1; tif.c_wreg = 3'd2; tif.c_wdata = 16'h0002;
    tick(); clear_commit();
    total++; if (fail !== 1'b1 || err_code !== 2'd1) begin bad++; $display("FAIL mismatch_code got fail=%0b code=%0d want 1/1", fail, err_code); end
    total++; if (err_cycle !== 16'd4) begin bad++; $display("FAIL mismatch_cycle got=%0d want=4", err_cycle); end
    tif.c_regwrite = 1'b1; tif.c_wreg = 3'd2; tif.c_wdata = 16'h0001;
    tick(); clear_commit();
    total++; if (check_count !== 16'd0 || err_code !== 2'd1 || pass !== 1'b0) begin bad++; $display("FAIL mismatch_sticky got count=%0d code=%0d pass=%0b want 0/1/0", check_count, err_code, pass); end
  endtask

  task automatic test_starve();
    do_reset();
    start_run();
    tif.c_memwrite = 1'b1; tif.c_maddr = 16'h0001; tif.c_mdin = 16'h0002;
    tick(); clear_commit();
    total++; if (err_code !== 2'd2 || fail !== 1'b1) begin bad++; $display("FAIL starve_code got code=%0d fail=%0b want 2/1", err_code, fail); end
    total++; if (check_count !== 16'd0 || err_cycle !== 16'd0) begin bad++; $display("FAIL starve_counts got count=%0d cycle=%0d want 0/0", check_count, err_cycle); end
  endtask

  task automatic test_extra();
    do_reset();
    push_rec(2'd3, 16'h0000, 16'h0000);
    push_rec(2'd0, 16'h0000, 16'h0000);
    start_run();
    tif.c_halt = 1'b1;
    tick(); clear_commit();
    total++; if (err_code !== 2'd3 || pass !== 1'b0 || fail !== 1'b1) begin bad++; $display("FAIL extra_code got code=%0d pass=%0b fail=%0b want 3/0/1", err_code, pass, fail); end
    total++; if (check_count !== 16'd1) begin bad++; $display("FAIL extra_count got=%0d want=1", check_count); end
  endtask

  task automatic test_back_to_back();
    int  cnt;
    int  p;
    logic acc;
    do_reset();
    for (int i = 0; i < 8; i++) push_rec(2'd0, 16'(i % 8), 16'(16'h0100 + i));
    total++; if (tif.exp_ready !== 1'b0) begin bad++; $display("FAIL b2b_full_ready got=%0b want=0", tif.exp_ready); end
    p = 8; cnt = 8;
    tif.exp_valid = 1'b1; tif.exp_kind = 2'd0; tif.exp_tag = 16'(p % 8); tif.exp_value = 16'(16'h0100 + p);
    start_run();
    for (int c = 0; c < 20; c++) begin
      tif.c_regwrite = 1'b1; tif.c_wreg = c[2:0]; tif.c_wdata = 16'(16'h0100 + c);
      if (p < 20) begin
        tif.exp_valid = 1'b1; tif.exp_tag = 16'(p % 8); tif.exp_value = 16'(16'h0100 + p);
      end else begin
        tif.exp_valid = 1'b0;
      end
      total++; if (tif.exp_ready !== (cnt < 8)) begin bad++; $display("FAIL b2b_ready c=%0d got=%0b want=%0b", c, tif.exp_ready, cnt < 8); end
      acc = tif.exp_valid && tif.exp_ready;
      tick();
      cnt = cnt - 1 + (acc ? 1 : 0);
      if (acc) p++;
      total++; if (check_count !== 16'(c + 1)) begin bad++; $display("FAIL b2b_count c=%0d got=%0d want=%0d", c, check_count, c + 1); end
    end
    clear_commit(); tif.exp_valid = 1'b0;
    total++; if (fail !== 1'b0 || busy !== 1'b1 || check_count !== 16'd20) begin bad++; $display("FAIL b2b_end got fail=%0b busy=%0b count=%0d want 0/1/20", fail, busy, check_count); end
    // Reset mid-run with a bad commit and an offered record: neither may stick.
    tif.exp_valid = 1'b1; tif.exp_tag = 16'd0; tif.exp_value = 16'd0;
    tif.c_regwrite = 1'b1; tif.c_wreg = 3'd5; tif.c_wdata = 16'hBEEF;
    rst = 1'b1;
    tick();
    rst = 1'b0; tif.exp_valid = 1'b0; clear_commit();
    total++; if (busy !== 1'b0 || pass !== 1'b0 || fail !== 1'b0) begin bad++; $display("FAIL b2b_rst_state got busy=%0b pass=%0b fail=%0b want 0/0/0", busy, pass, fail); end
    total++; if (err_code !== 2'd0 || err_cycle !== 16'd0 || check_count !== 16'd0) begin bad++; $display("FAIL b2b_rst_regs got code=%0d cycle=%0d count=%0d want 0/0/0", err_code, err_cycle, check_count); end
    total++; if (tif.exp_ready !== 1'b1) begin bad++; $display("FAIL b2b_rst_ready got=%0b want=1", tif.exp_ready); end
    start_run();
    tif.c_regwrite = 1'b1; tif.c_wreg = 3'd0; tif.c_wdata = 16'd0;
    tick(); clear_commit();
    total++; if (err_code !== 2'd2) begin bad++; $display("FAIL b2b_rst_fifo_empty got code=%0d want=2", err_code); end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0;
    tif.exp_valid = 1'b0; tif.exp_kind = '0; tif.exp_tag = '0; tif.exp_value = '0;
    clear_commit();
    tick();
    test_reset();
    test_basic();
    test_multi();
    test_mismatch();
    test_starve();
    test_extra();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
